// File: rtl/bram_pingpong_ctrl_pkg.sv
// Shared types and sizing helpers for the ping-pong BRAM write/read controller.
package bram_pingpong_ctrl_pkg;

    // Ownership state of one matrix buffer.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } buf_state_e;

    // Elements per lane per matrix; M*M must be a multiple of N.
    function automatic int calc_depth(input int m, input int n);
        return (m * m) / n;
    endfunction

    // Address width for a lane bank, never narrower than one bit.
    function automatic int calc_aw(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bram_pingpong_ctrl_lane_addr_ctr.sv
// Per-lane BRAM write address counter; flags the lane once it has written a whole matrix share.
module lane_addr_ctr #(
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    input  logic          clear,
    output logic [AW-1:0] addr,
    output logic          done,
    output logic          wrap
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // The accept that writes the last slot wraps the address back to 0.
    assign wrap = accept && (addr == LAST);

    // Address advances per accept; done latches at the wrap and holds until the buffer completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            done <= 1'b0;
        end else begin
            if (accept) begin
                addr <= wrap ? '0 : addr + AW'(1);
            end
            if (clear) begin
                done <= 1'b0;
            end else if (wrap) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong controller: N lanes fill one of two BRAM buffers while the reader drains the other.
module bram_pingpong_ctrl
    import bram_pingpong_ctrl_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N   = 3,
    parameter int M   = 6,
    localparam int DEPTH = calc_depth(M, N),
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_valid,
    input  logic [N-1:0][D_W-1:0] in_data,
    output logic [N-1:0]          in_ready,
    output logic [N-1:0]          wr_en_bram,
    output logic [N-1:0][AW-1:0]  wr_addr_bram,
    output logic [N-1:0][D_W-1:0] wr_data_bram,
    output logic                  wr_bank,
    output logic                  rd_start,
    output logic                  rd_bank,
    input  logic                  rd_done,
    output logic [1:0][1:0]       buf_state
);

    buf_state_e state_q [2];
    buf_state_e state_n [2];
    logic       wr_bank_q, wr_bank_n;
    logic       rd_ptr_q, rd_ptr_n;
    logic       other_bank;

    logic [N-1:0] lane_done;
    logic [N-1:0] lane_wrap;
    logic         filling;
    logic         reading_any;
    logic         complete;
    logic         rd_done_acc;

    assign other_bank  = ~wr_bank_q;
    assign filling     = (state_q[wr_bank_q] == FILLING);
    assign reading_any = (state_q[0] == READING) || (state_q[1] == READING);
    assign rd_done_acc = rd_done && reading_any;
    // Completion counts lanes finishing on this very cycle, so the swap costs no bubble.
    assign complete    = filling && (&(lane_done | lane_wrap));

    genvar g;
    for (g = 0; g < N; g++) begin : g_lane
        lane_addr_ctr #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .accept (wr_en_bram[g]),
            .clear  (complete),
            .addr   (wr_addr_bram[g]),
            .done   (lane_done[g]),
            .wrap   (lane_wrap[g])
        );
    end

    // Buffer states, write-side bank and read-order pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= FILLING;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q[0] <= state_n[0];
            state_q[1] <= state_n[1];
            wr_bank_q  <= wr_bank_n;
            rd_ptr_q   <= rd_ptr_n;
        end
    end

    // Next-state: read release first, then read handoff, then write-side transitions which win over release.
    always_comb begin
        state_n[0] = state_q[0];
        state_n[1] = state_q[1];
        wr_bank_n  = wr_bank_q;
        rd_ptr_n   = rd_ptr_q;

        // The reading buffer is always the one rd_ptr points at.
        if (rd_done_acc) begin
            state_n[rd_ptr_q] = EMPTY;
            rd_ptr_n          = ~rd_ptr_q;
        end

        if (rd_start) begin
            state_n[rd_ptr_q] = READING;
        end

        if (filling) begin
            if (complete) begin
                state_n[wr_bank_q] = FULL;
                // Released-this-cycle counts as free so the writer keeps streaming.
                if ((state_q[other_bank] == EMPTY) ||
                    ((state_q[other_bank] == READING) && rd_done)) begin
                    state_n[other_bank] = FILLING;
                    wr_bank_n           = other_bank;
                end
            end
        end else if (state_q[other_bank] == EMPTY) begin
            // Writer was stalled; resume into the buffer the reader just freed.
            state_n[other_bank] = FILLING;
            wr_bank_n           = other_bank;
        end
    end

    // Handshake and read handoff outputs.
    always_comb begin
        in_ready   = {N{filling}} & ~lane_done;
        wr_en_bram = in_valid & in_ready & {N{~rst}};
        rd_start   = ~rst && (state_q[rd_ptr_q] == FULL) && !reading_any;
    end

    assign wr_data_bram = in_data;
    assign wr_bank      = wr_bank_q;
    // rd_ptr only moves on rd_done, so it names the reader's buffer for the whole read.
    assign rd_bank      = rd_ptr_q;
    assign buf_state[0] = state_q[0];
    assign buf_state[1] = state_q[1];

endmodule
